// File: rtl/servo_ramp.sv
// Servo duty ramp generator. It accepts a target duty, slews duty by at most STEP
// per PWM period, and holds for HOLD_PERIODS periods after the target is reached.
module servo_ramp #(
  parameter int unsigned PERIOD_CNT   = 50000,
  parameter int unsigned MIN_DUTY     = 2500,
  parameter int unsigned MAX_DUTY     = 5000,
  parameter int unsigned INIT_DUTY    = 3750,
  parameter int unsigned STEP         = 50,
  parameter int unsigned HOLD_PERIODS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tgt_valid,
  input  logic [15:0] tgt_duty,
  output logic        tgt_ready,
  output logic [15:0] duty,
  output logic        period_start,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  localparam logic [15:0] LAST_CNT = 16'(PERIOD_CNT - 1);
  localparam logic [15:0] MIN_W    = 16'(MIN_DUTY);
  localparam logic [15:0] MAX_W    = 16'(MAX_DUTY);
  localparam logic [15:0] INIT_W   = 16'(INIT_DUTY);
  localparam logic [15:0] STEP_W   = 16'(STEP);
  localparam logic [15:0] HOLD_W   = 16'(HOLD_PERIODS);

  state_t      state_q;
  logic [15:0] pcnt_q, duty_q, target_q, hold_q;
  logic [15:0] pcnt_d, duty_d, tgt_clamped;
  logic        boundary, ramp_done;

  always_comb begin
    boundary = (pcnt_q == LAST_CNT);
    pcnt_d   = boundary ? '0 : pcnt_q + 16'd1;

    tgt_clamped = tgt_duty;
    if (tgt_duty < MIN_W)      tgt_clamped = MIN_W;
    else if (tgt_duty > MAX_W) tgt_clamped = MAX_W;

    // Subtract in the direction of travel so the distance never wraps.
    ramp_done = 1'b0;
    duty_d    = target_q;
    if (target_q >= duty_q) begin
      ramp_done = (target_q - duty_q) <= STEP_W;
      if (!ramp_done) duty_d = duty_q + STEP_W;
    end else begin
      ramp_done = (duty_q - target_q) <= STEP_W;
      if (!ramp_done) duty_d = duty_q - STEP_W;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q   <= '0;
      duty_q   <= INIT_W;
      target_q <= INIT_W;
      hold_q   <= '0;
      state_q  <= IDLE;
    end else begin
      pcnt_q <= pcnt_d;
      case (state_q)
        IDLE: begin
          if (tgt_valid) begin
            target_q <= tgt_clamped;
            state_q  <= RAMP;
          end
        end
        RAMP: begin
          if (boundary) begin
            duty_q <= duty_d;
            if (ramp_done) begin
              if (HOLD_PERIODS == 0) begin
                state_q <= IDLE;
              end else begin
                hold_q  <= HOLD_W;
                state_q <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (boundary) begin
            hold_q <= hold_q - 16'd1;
            if (hold_q == 16'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign duty         = duty_q;
  assign period_start = (pcnt_q == '0) && !reset;
  assign tgt_ready    = (state_q == IDLE) && !reset;
  assign busy         = (state_q != IDLE) && !reset;

endmodule

// File: tb/tb_servo_ramp.sv
// Randomized bench for servo_ramp: each accepted target is expanded into the list of
// duties expected at successive period starts, followed by the hold periods.
module tb_servo_ramp;

  localparam int PER  = 10;
  localparam int MIN  = 1000;
  localparam int MAX  = 2000;
  localparam int INIT = 1500;
  localparam int STP  = 100;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tgt_valid = 1'b0;
  logic [15:0] tgt_duty = '0;
  logic        tgt_ready, period_start, busy;
  logic [15:0] duty;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mdl_duty = INIT;

  servo_ramp #(
    .PERIOD_CNT(PER), .MIN_DUTY(MIN), .MAX_DUTY(MAX),
    .INIT_DUTY(INIT), .STEP(STP), .HOLD_PERIODS(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_duty(tgt_duty),
    .tgt_ready(tgt_ready), .duty(duty), .period_start(period_start), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (duty !== 16'(INIT)) begin bad++; $display("FAIL rst_duty got=%0d want=%0d", duty, INIT); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL rst_pstart got=%0b want=0", period_start); end
    total++; if (tgt_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", tgt_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    reset = 1'b0;
    #1;
    cyc = 0;
    mdl_duty = INIT;
    for (int i = 0; i < 3 * PER; i++) begin
      total++;
      if (period_start !== ((cyc % PER) == 0)) begin
        bad++; $display("FAIL pstart_cadence cyc=%0d got=%0b want=%0b", cyc, period_start, (cyc % PER) == 0);
      end
      total++; if (tgt_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0b want=1", tgt_ready); end
      total++; if (duty !== 16'(INIT)) begin bad++; $display("FAIL idle_duty got=%0d want=%0d", duty, INIT); end
      tick();
    end
  endtask

  // mode 0: accept now, 1: accept on a boundary cycle, 2: random delay first
  task automatic run_move(input int val, input int mode, input bit inject);
    int t, d, n, cur;
    bit on_boundary;
    int exp_q[$];
    if (mode == 1) while ((cyc % PER) != PER - 1) tick();
    else if (mode == 2) repeat ($urandom_range(0, 12)) tick();
    total++; if (tgt_ready !== 1'b1) begin bad++; $display("FAIL ready_before_move got=%0b want=1", tgt_ready); end
    t = (val < MIN) ? MIN : (val > MAX) ? MAX : val;
    d = mdl_duty;
    do begin
      if (t > d) d = (t - d <= STP) ? t : d + STP;
      else       d = (d - t <= STP) ? t : d - STP;
      exp_q.push_back(d);
    end while (d != t);
    on_boundary = ((cyc % PER) == PER - 1);
    tgt_valid = 1'b1;
    tgt_duty  = 16'(val);
    tick();
    tgt_valid = 1'b0;
    cur = mdl_duty;
    if (on_boundary) begin
      total++; if (duty !== 16'(cur)) begin bad++; $display("FAIL no_step_on_hs_boundary got=%0d want=%0d", duty, cur); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_hs got=%0b want=1", busy); end
      tick();
    end
    n = exp_q.size() + HOLD;
    for (int k = 1; k <= n; k++) begin
      while ((cyc % PER) != 0) begin
        total++; if (duty !== 16'(cur)) begin bad++; $display("FAIL duty_stable got=%0d want=%0d", duty, cur); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid got=%0b want=1", busy); end
        total++; if (period_start !== 1'b0) begin bad++; $display("FAIL pstart_mid got=%0b want=0", period_start); end
        if (inject && k == 1 && (cyc % PER) == 3) begin
          tgt_valid = 1'b1; tgt_duty = 16'd1200;
          tick();
          tgt_valid = 1'b0;
        end else begin
          tick();
        end
      end
      if (k <= exp_q.size()) cur = exp_q[k-1];
      total++; if (period_start !== 1'b1) begin bad++; $display("FAIL pstart_step k=%0d got=%0b want=1", k, period_start); end
      total++; if (duty !== 16'(cur)) begin bad++; $display("FAIL step_duty k=%0d got=%0d want=%0d", k, duty, cur); end
      total++; if (busy !== (k < n)) begin bad++; $display("FAIL step_busy k=%0d got=%0b want=%0b", k, busy, k < n); end
      total++; if (tgt_ready !== (k == n)) begin bad++; $display("FAIL step_ready k=%0d got=%0b want=%0b", k, tgt_ready, k == n); end
      if (k < n) tick();
    end
    mdl_duty = t;
  endtask

  task automatic test_ramp_up();
    run_move(1800, 0, 1'b0);
  endtask

  task automatic test_small_step();
    run_move(1500, 2, 1'b0);
    run_move(1450, 0, 1'b0);
  endtask

  task automatic test_clamp();
    run_move(3000, 0, 1'b0);
    run_move(0, 2, 1'b0);
  endtask

  task automatic test_equal_target();
    run_move(mdl_duty, 0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_move(1500, 0, 1'b1);
  endtask

  task automatic test_boundary_handshake();
    run_move(1700, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_move(int'($urandom_range(700, 2300)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid_ramp();
    run_move(1500, 0, 1'b0);
    tgt_valid = 1'b1;
    tgt_duty  = 16'd1900;
    tick();
    tgt_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      while ((cyc % PER) != 0) tick();
    end
    total++; if (duty !== 16'd1700) begin bad++; $display("FAIL mid_ramp_duty got=%0d want=1700", duty); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_ramp_busy got=%0b want=1", busy); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_in_reset got=%0b want=0", busy); end
    total++; if (tgt_ready !== 1'b0) begin bad++; $display("FAIL ready_in_reset got=%0b want=0", tgt_ready); end
    tick();
    total++; if (duty !== 16'(INIT)) begin bad++; $display("FAIL reset_abandon_duty got=%0d want=%0d", duty, INIT); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_pstart got=%0b want=0", period_start); end
    reset = 1'b0;
    #1;
    cyc = 0;
    mdl_duty = INIT;
    for (int i = 0; i < 2 * PER + 3; i++) begin
      total++; if (period_start !== ((cyc % PER) == 0)) begin bad++; $display("FAIL post_reset_pstart cyc=%0d got=%0b", cyc, period_start); end
      total++; if (duty !== 16'(INIT)) begin bad++; $display("FAIL no_resume_duty got=%0d want=%0d", duty, INIT); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL no_resume_busy got=%0b want=0", busy); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_small_step();
    test_clamp();
    test_equal_target();
    test_busy_ignore();
    test_boundary_handshake();
    test_random();
    test_reset_mid_ramp();
    test_boundary_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
